// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   state_t       FSM encoding (S_REQ, S_WAIT, S_OUT), also exposed on the debug port
//   IFU_NOP       canonical NOP (addi x0, x0, 0) returned on any fetch fault
//   IFU_RESET_PC  default PC loaded on reset
//   pc_misaligned helper: true when the low two PC bits are non-zero
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  function automatic logic pc_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// ifu_if: bundles the three channels around the fetch unit.
//   imem request : imem_req_valid/imem_req_ready/imem_req_addr (ifu -> memory)
//   imem response: imem_rsp_valid/imem_rsp_data/imem_rsp_err (memory -> ifu)
//   decode       : id_valid/id_ready/id_inst/id_pc/id_fault (ifu -> decode)
//   redirect     : redirect_valid/redirect_pc (execute -> ifu)
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both high; the sender keeps valid and
// its payload stable until that edge, except that a redirect may retarget the
// pending fetch address or withdraw the decode offer. imem_rsp_valid is a
// one-cycle pulse with no ready; it is only meaningful while a request is
// outstanding.
// Modports: master = fetch unit side, slave = environment side.
interface ifu_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic            id_fault;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output id_valid, id_inst, id_pc, id_fault,
    input  id_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  id_valid, id_inst, id_pc, id_fault,
    output id_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter register.
//   clk, rst       clock, synchronous active-high reset (loads RESET_PC)
//   redirect_valid load redirect_pc (highest priority)
//   redirect_pc    redirect target
//   inc_en         advance by 4 (decode handshake)
//   pc             current program counter
// The +4 increment wraps modulo 2^XLEN.
module ifu_pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inc_en,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (inc_en) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Owns the PC, issues one memory request per
// instruction, and presents the fetched word with its PC to decode. The PC
// advances only on a decode handshake; redirects from execute override it.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             ifu_if.master: imem request/response, decode, redirect
//   dbg_state       current FSM state
//   perf_fetch_cnt  (IFU_PERF_CNT_EN only) decode handshakes, wrapping
//   perf_stall_cnt  (IFU_PERF_CNT_EN only) cycles spent in S_WAIT, wrapping
// Build option: define IFU_PERF_CNT_EN to add the two performance counters.
module ifu
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic        clk,
  input  logic        rst,
  ifu_if.master       bus,
  output state_t      dbg_state
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  state_t          state, state_nxt;
  logic            drop, drop_nxt;
  logic [XLEN-1:0] pc;
  logic            misaligned;
  logic            req_valid;
  logic            id_valid;
  logic            req_fire;
  logic            id_fire;
  logic            load_rsp;
  logic            load_fault;

  // Output register presented to decode.
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_fault;

  assign misaligned = pc_misaligned(pc[1:0]);

  ifu_pc_reg #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(bus.redirect_valid),
    .redirect_pc   (bus.redirect_pc),
    .inc_en        (id_fire),
    .pc            (pc)
  );

  // State register. drop marks an outstanding request whose response must be
  // thrown away because the PC was redirected after it was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  // Next-state logic. Redirect takes priority over every other event.
  always_comb begin
    state_nxt  = state;
    drop_nxt   = drop;
    load_rsp   = 1'b0;
    load_fault = 1'b0;
    case (state)
      S_REQ: begin
        if (bus.redirect_valid) begin
          // A request accepted this cycle still gets a response; skip it.
          if (req_fire) begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end else if (misaligned) begin
          // No memory access for a misaligned PC; report the fault directly.
          state_nxt  = S_OUT;
          load_fault = 1'b1;
        end else if (req_fire) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop || bus.redirect_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = S_OUT;
            load_rsp  = 1'b1;
          end
        end else if (bus.redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      S_OUT: begin
        // id_valid is already low under redirect, so id_ready is ignored then.
        if (bus.redirect_valid || bus.id_ready) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    req_valid = 1'b0;
    id_valid  = 1'b0;
    case (state)
      S_REQ:   req_valid = !misaligned;
      S_OUT:   id_valid  = !bus.redirect_valid;
      default: ;
    endcase
  end

  assign req_fire = req_valid && bus.imem_req_ready;
  assign id_fire  = id_valid && bus.id_ready;

  // Output register: loaded on an accepted response or a misaligned-PC fault,
  // otherwise held, which keeps decode's view stable during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst  <= 32'h0;
      out_pc    <= RESET_PC;
      out_fault <= 1'b0;
    end else if (load_rsp) begin
      out_inst  <= bus.imem_rsp_err ? IFU_NOP : bus.imem_rsp_data;
      out_pc    <= pc;
      out_fault <= bus.imem_rsp_err;
    end else if (load_fault) begin
      out_inst  <= IFU_NOP;
      out_pc    <= pc;
      out_fault <= 1'b1;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = id_valid;
  assign bus.id_inst        = out_inst;
  assign bus.id_pc          = out_pc;
  assign bus.id_fault       = out_fault;
  assign dbg_state          = state;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (id_fire) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (state == S_WAIT) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for ifu. A cycle-by-cycle vector table covers
// fetch, stalls, redirects, misaligned PC, access fault and PC wrap; short
// hand-written sequences cover reset values, steady-state throughput and
// reset in the middle of a fetch.
module tb_ifu;
  import ifu_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_if #(.XLEN(32)) bus ();
  state_t dbg_state;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .dbg_state(dbg_state)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    string       tag;
    logic        rdy;
    logic        rv;
    logic [31:0] data;
    logic        err;
    logic        idr;
    logic        redv;
    logic [31:0] redpc;
    logic        rqv;
    logic [31:0] addr;
    logic        idv;
    logic [31:0] inst;
    logic [31:0] idpc;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input string tag, input logic rdy, input logic rv,
                     input logic [31:0] data, input logic err, input logic idr,
                     input logic redv, input logic [31:0] redpc,
                     input logic rqv, input logic [31:0] addr, input logic idv,
                     input logic [31:0] inst, input logic [31:0] idpc,
                     input logic flt);
    vec_t v;
    v.tag = tag; v.rdy = rdy; v.rv = rv; v.data = data; v.err = err;
    v.idr = idr; v.redv = redv; v.redpc = redpc; v.rqv = rqv; v.addr = addr;
    v.idv = idv; v.inst = inst; v.idpc = idpc; v.flt = flt;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] data,
                       input logic err, input logic idr, input logic redv,
                       input logic [31:0] redpc);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = data;
    bus.imem_rsp_err   = err;
    bus.id_ready       = idr;
    bus.redirect_valid = redv;
    bus.redirect_pc    = redpc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset id_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("reset id_fault", {31'b0, bus.id_fault}, 32'h0);
    chk("reset id_inst", bus.id_inst, 32'h0);
    chk("reset id_pc", bus.id_pc, 32'h8000_0000);
    chk("reset state", {30'b0, dbg_state}, {30'b0, S_REQ});
  endtask

  task automatic apply(input vec_t v);
    logic ok;
    @(negedge clk);
    rst = 1'b0;
    drive(v.rdy, v.rv, v.data, v.err, v.idr, v.redv, v.redpc);
    #1;
    n_vec++;
    ok = (bus.imem_req_valid === v.rqv) && (bus.imem_req_addr === v.addr) &&
         (bus.id_valid === v.idv) && (bus.id_inst === v.inst) &&
         (bus.id_pc === v.idpc) && (bus.id_fault === v.flt);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got rqv=%b addr=%08h idv=%b inst=%08h pc=%08h flt=%b expected rqv=%b addr=%08h idv=%b inst=%08h pc=%08h flt=%b",
               v.tag, bus.imem_req_valid, bus.imem_req_addr, bus.id_valid,
               bus.id_inst, bus.id_pc, bus.id_fault, v.rqv, v.addr, v.idv,
               v.inst, v.idpc, v.flt);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------------------------------------------------------- test
  logic [31:0] exp_q[$];

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //   tag          rdy  rv   data          err  idr  redv redpc         | rqv  addr          idv  inst          id_pc         flt
    row("stall0",     1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0000,1'b0,32'h0,        32'h8000_0000,1'b0);
    row("rsp_in_req", 1'b0,1'b1,32'hBAD0_0BAD,1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0000,1'b0,32'h0,        32'h8000_0000,1'b0);
    row("stall2",     1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0000,1'b0,32'h0,        32'h8000_0000,1'b0);
    row("stall3",     1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0000,1'b0,32'h0,        32'h8000_0000,1'b0);
    row("accept0",    1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0000,1'b0,32'h0,        32'h8000_0000,1'b0);
    row("rsp0",       1'b1,1'b1,32'h0000_0093,1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0000,1'b0,32'h0,        32'h8000_0000,1'b0);
    row("out0",       1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0000,1'b1,32'h0000_0093,32'h8000_0000,1'b0);
    row("req1",       1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0004,1'b0,32'h0000_0093,32'h8000_0000,1'b0);
    row("rsp1",       1'b1,1'b1,32'h0010_0113,1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0004,1'b0,32'h0000_0093,32'h8000_0000,1'b0);
    row("out1",       1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0004,1'b1,32'h0010_0113,32'h8000_0004,1'b0);
    row("req2",       1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0008,1'b0,32'h0010_0113,32'h8000_0004,1'b0);
    row("rsp2",       1'b1,1'b1,32'h0020_0193,1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0008,1'b0,32'h0010_0113,32'h8000_0004,1'b0);
    row("out2",       1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0008,1'b1,32'h0020_0193,32'h8000_0008,1'b0);
    // redirect while waiting: stale response dropped
    row("req3",       1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_000C,1'b0,32'h0020_0193,32'h8000_0008,1'b0);
    row("wait_redir", 1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8000_0100, 1'b0,32'h8000_000C,1'b0,32'h0020_0193,32'h8000_0008,1'b0);
    row("stale_rsp",  1'b1,1'b1,32'h0BAD_F00D,1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0100,1'b0,32'h0020_0193,32'h8000_0008,1'b0);
    row("req_100",    1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0100,1'b0,32'h0020_0193,32'h8000_0008,1'b0);
    row("rsp_100",    1'b1,1'b1,32'hDEAD_BEEF,1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0100,1'b0,32'h0020_0193,32'h8000_0008,1'b0);
    // decode stall for 5 cycles
    for (int i = 0; i < 5; i++)
      row("id_stall", 1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,         1'b0,32'h8000_0100,1'b1,32'hDEAD_BEEF,32'h8000_0100,1'b0);
    row("id_release", 1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0100,1'b1,32'hDEAD_BEEF,32'h8000_0100,1'b0);
    // redirect to a misaligned PC while a request is pending but not accepted
    row("req_redir",  1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8000_0102, 1'b1,32'h8000_0104,1'b0,32'hDEAD_BEEF,32'h8000_0100,1'b0);
    row("misaligned", 1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0102,1'b0,32'hDEAD_BEEF,32'h8000_0100,1'b0);
    row("mis_fault",  1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,         1'b0,32'h8000_0102,1'b1,32'h0000_0013,32'h8000_0102,1'b1);
    // redirect in S_OUT with id_ready high: held instruction discarded
    row("out_redir",  1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'hFFFF_FFFC, 1'b0,32'h8000_0102,1'b0,32'h0000_0013,32'h8000_0102,1'b1);
    // access fault at the top of the address space, then wrap
    row("req_top",    1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'hFFFF_FFFC,1'b0,32'h0000_0013,32'h8000_0102,1'b1);
    row("rsp_err",    1'b1,1'b1,32'h1234_5678,1'b1,1'b1,1'b0,32'h0,         1'b0,32'hFFFF_FFFC,1'b0,32'h0000_0013,32'h8000_0102,1'b1);
    row("out_err",    1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'hFFFF_FFFC,1'b1,32'h0000_0013,32'hFFFF_FFFC,1'b1);
    // wrapped to 0; redirect in the same cycle the request is accepted
    row("req_wrap",   1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8000_0200, 1'b1,32'h0000_0000,1'b0,32'h0000_0013,32'hFFFF_FFFC,1'b1);
    row("drop_wait",  1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0200,1'b0,32'h0000_0013,32'hFFFF_FFFC,1'b1);
    row("drop_rsp",   1'b1,1'b1,32'h0BAD_F00D,1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0200,1'b0,32'h0000_0013,32'hFFFF_FFFC,1'b1);
    row("req_200",    1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0200,1'b0,32'h0000_0013,32'hFFFF_FFFC,1'b1);
    row("rsp_200",    1'b1,1'b1,32'h00A0_0093,1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0200,1'b0,32'h0000_0013,32'hFFFF_FFFC,1'b1);
    row("out_200",    1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b0,32'h8000_0200,1'b1,32'h00A0_0093,32'h8000_0200,1'b0);
    // redirect together with the response
    row("req_204",    1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0204,1'b0,32'h00A0_0093,32'h8000_0200,1'b0);
    row("rsp_redir",  1'b1,1'b1,32'h0BAD_F00D,1'b0,1'b1,1'b1,32'h8000_0300, 1'b0,32'h8000_0204,1'b0,32'h00A0_0093,32'h8000_0200,1'b0);
    row("req_300",    1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8000_0300,1'b0,32'h00A0_0093,32'h8000_0200,1'b0);

    // ---- reset values, then the vector table
    do_reset();
    foreach (vecs[i]) apply(vecs[i]);

    // ---- throughput with zero-wait memory and an always-ready decode
    do_reset();
    begin
      int          fetched = 0;
      int          accepts = 0;
      int          last = -1;
      logic        acc_d = 1'b0;
      logic [31:0] acc_addr = 32'h0;
      for (int cyc = 0; cyc < 60 && fetched < 4; cyc++) begin
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, acc_d, acc_d ? mem_word(acc_addr) : 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        if (bus.id_valid) begin
          chk("tp id_pc", bus.id_pc, 32'h8000_0000 + 32'(4 * fetched));
          if (exp_q.size() == 0) begin
            chk("tp unexpected instruction", 32'h1, 32'h0);
          end else begin
            chk("tp id_inst", bus.id_inst, exp_q.pop_front());
          end
          if (fetched == 0) chk("tp first latency", 32'(cyc), 32'd2);
          else              chk("tp spacing", 32'(cyc - last), 32'd3);
          last = cyc;
          fetched++;
        end
        acc_d = bus.imem_req_valid && bus.imem_req_ready;
        if (acc_d) begin
          chk("tp req addr", bus.imem_req_addr, 32'h8000_0000 + 32'(4 * accepts));
          acc_addr = bus.imem_req_addr;
          exp_q.push_back(mem_word(bus.imem_req_addr));
          accepts++;
        end
      end
      chk("tp fetch count", 32'(fetched), 32'd4);
    end

    // ---- reset while a request is outstanding; late response ignored
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("mid accept", {31'b0, bus.imem_req_valid}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("mid rst state", {30'b0, dbg_state}, {30'b0, S_REQ});
    chk("mid rst addr", bus.imem_req_addr, 32'h8000_0000);
    chk("mid rst id_inst", bus.id_inst, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("late rsp state", {30'b0, dbg_state}, {30'b0, S_REQ});
    chk("late rsp id_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("late rsp req_valid", {31'b0, bus.imem_req_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle RISC-V core. It owns the program counter and issues one fetch request per instruction to instruction memory over a valid/ready request channel. It returns the fetched word with its PC to decode over a valid/ready handshake, and accepts redirects (branch/jump targets) from execute. It replaces the free-running PC-plus-4 loop: PC advances only when decode accepts an instruction.

## Interface
Parameters:
- `XLEN`, 32, datapath and address width.
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  fetch address (current PC).
- `imem_rsp_valid`  in  1  response valid; single-cycle pulse.
- `imem_rsp_data`  in  32  fetched instruction word.
- `imem_rsp_err`  in  1  access fault, qualified by `imem_rsp_valid`.
- `id_valid`  out  1  instruction available to decode.
- `id_ready`  in  1  decode accepts it.
- `id_inst`  out  32  instruction word.
- `id_pc`  out  XLEN  PC of `id_inst`.
- `id_fault`  out  1  fetch fault; `id_inst` = NOP.
- `redirect_valid`  in  1  load new PC.
- `redirect_pc`  in  XLEN  redirect target.

## Operation
- States: S_REQ, S_WAIT, S_OUT.
- **S_REQ**
  - Drive `imem_req_valid`=1 and `imem_req_addr`=pc.
  - On `imem_req_ready`, go to S_WAIT.
  - The address stays stable until accepted, except when a redirect changes it.
- **S_WAIT**
  - On `imem_rsp_valid`, latch data, err and pc into the output register, then go to S_OUT.
  - If the `drop` flag is set, discard the response, clear `drop`, and go to S_REQ.
- **S_OUT**
  - `id_valid` = (state==S_OUT) && !`redirect_valid`.
  - On `id_valid && id_ready`: pc <= pc + 4 (modulo 2^XLEN, wraps silently), go to S_REQ.
- **Redirect** (any state, priority over everything):
  - pc <= `redirect_pc`.
  - In S_REQ accepted the same cycle, or in S_WAIT without a response the same cycle: set `drop`, remain in or enter S_WAIT.
  - In S_WAIT with a response the same cycle: discard it and go to S_REQ.
  - In S_OUT: discard the held instruction and go to S_REQ; a same-cycle `id_ready` is ignored.
  - In S_REQ, not accepted: stay in S_REQ with the new address.
- **Misaligned PC** (pc[1:0]≠0, only reachable via redirect):
  - Issue no memory request.
  - Enter S_OUT directly with `id_fault`=1, `id_inst`=32'h0000_0013, `id_pc`=pc.
- **Access fault**: `imem_rsp_err`=1 gives `id_fault`=1 and `id_inst`=NOP.
- At most one request is outstanding at any time.

## Timing
- **Reset values**:
  - pc = RESET_PC, state = S_REQ, drop = 0.
  - `id_valid`, `id_fault` = 0; `id_inst` = 0; `id_pc` = RESET_PC.
  - `imem_req_valid` = 1 in the first cycle after `rst` falls.
- Reset mid-operation abandons any outstanding request. A response arriving after reset is ignored, because it arrives in S_REQ.
- **Response timing**: a response arrives no earlier than the cycle after acceptance. `imem_rsp_valid` outside S_WAIT is ignored.
- **Latency**, with zero-wait memory (ready=1, response 1 cycle after accept): request cycle N, response N+1, `id_valid` N+2.
- **Throughput**: one instruction per 3 cycles when decode is always ready.
- **Decode stall**: `id_inst`/`id_pc`/`id_fault` are held stable while `id_valid`=1 and `id_ready`=0.

## Configuration
- `IFU_PERF_CNT_EN` defined adds two outputs, each 32 bits, reset to 0, wrapping:
  - `perf_fetch_cnt`: increments on each `id_valid && id_ready`.
  - `perf_stall_cnt`: increments on each cycle spent in S_WAIT.
- Undefined: these ports and counters do not exist.

## Structure
- Package `ifu_pkg`:
  - state enum (S_REQ, S_WAIT, S_OUT)
  - `IFU_NOP` = 32'h0000_0013
  - default `RESET_PC`
- Sub-module `ifu_pc_reg`: PC register with reset value, redirect mux, and +4 increment. Enable on decode handshake or redirect.
- FSM, drop flag, and output register live in `ifu`.

## Test plan
- Reset release, memory ready=1, response after 1 cycle, decode ready=1 → addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 issued; `id_pc` matches each; one instruction every 3 cycles.
- `imem_req_ready` low for 4 cycles → `imem_req_addr` stable at 0x8000_0000 throughout; exactly one accept.
- Redirect to 0x8000_0100 while in S_WAIT → stale response discarded (no `id_valid`); next request address is 0x8000_0100.
- `id_ready` low for 5 cycles with `id_inst`=0xDEADBEEF → outputs held; pc not incremented; advances to +4 only after handshake.
- Redirect to 0x8000_0102 → no memory request; `id_valid`=1, `id_fault`=1, `id_inst`=0x0000_0013, `id_pc`=0x8000_0102.
- `imem_rsp_err`=1; also pc=0xFFFF_FFFC then consumed → `id_fault`=1 with NOP; next fetch address wraps to 0x0000_0000.
